pad_func_seq: RTL and testbench
===============================

PAD_FUNC_SEQ -- requirements
Module: pad_func_seq

Interface
- REQ-001 SHALL have parameter NFUNC, default 4: number of functional owners multiplexed onto one pad (2..8).
- REQ-002 SHALL have parameter GUARD_CYC, default 2: output-disable cycles before a function switch (1..15).
- REQ-003 SHALL have parameter SETTLE_CYC, default 4: pull/input settle cycles after a switch (1..15).
- REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
- REQ-005 SHALL have port rst, input, 1: reset, synchronous, active-high.
- REQ-006 SHALL have port cfg_valid, input, 1: configuration request.
- REQ-007 SHALL have port cfg_ready, output, 1: controller accepts a configuration.
- REQ-008 SHALL have port cfg_func, input, $clog2(NFUNC): requested owner index.
- REQ-009 SHALL have port cfg_pu, cfg_pd, cfg_dr, cfg_sr, input, 1 each: requested pull-up, pull-down, drive strength and slew rate.
- REQ-010 SHALL have port cfg_err, output, 1: one-cycle pulse when a request is rejected.
- REQ-011 SHALL have port fn_a, fn_oe, fn_od, fn_os, input, NFUNC each: per-owner data, output enable, open-drain and open-source controls.
- REQ-012 SHALL have port fn_y, output, NFUNC: pad input returned to owners; only the selected bit is live.
- REQ-013 SHALL have port pad_a, pad_oe, pad_ie, pad_od, pad_os, pad_pu, pad_pd, pad_dr, pad_sr, output, 1 each: pad cell controls.
- REQ-014 SHALL have port pad_y, input, 1: pad cell Y.
- REQ-015 SHALL have port busy, output, 1: high in every state except IDLE and RUN.

Function
- REQ-016 SHALL implement states IDLE, DRAIN, SWITCH, SETTLE and RUN.
- REQ-017 SHALL drive cfg_ready=1 only in IDLE and RUN; a handshake is cfg_valid&cfg_ready at a rising edge.
- REQ-018 SHALL reject a handshake with cfg_pu=cfg_pd=1: pulse cfg_err next cycle, keep state and all pad outputs unchanged.
- REQ-019 SHALL on an accepted handshake latch all cfg_* fields and enter DRAIN next cycle.
- REQ-020 SHALL in DRAIN force pad_oe=0 and pad_ie=0, hold old func/pulls, and count GUARD_CYC cycles, then go to SWITCH.
- REQ-021 SHALL in SWITCH (exactly 1 cycle) load the latched func, pu, pd, dr and sr into the output registers, keep pad_oe=0 and pad_ie=0, then go to SETTLE.
- REQ-022 SHALL in SETTLE drive pad_ie=1 and pad_oe=0 for SETTLE_CYC cycles, then go to RUN.
- REQ-023 SHALL in RUN drive pad_oe, pad_a, pad_od and pad_os from the selected owner through one register stage (1-cycle latency), and drive pad_ie=1.
- REQ-024 SHALL in any state other than RUN drive pad_a=0, pad_od=0 and pad_os=0.
- REQ-025 SHALL drive fn_y[sel]=pad_y&pad_ie combinationally and all other fn_y bits 0.
- REQ-026 SHALL run the full sequence when the request names the currently active function; it SHALL NOT short-cut.
- REQ-027 SHALL reject cfg_func>=NFUNC exactly as in REQ-018.
- REQ-028 SHALL ignore cfg_valid while busy; a request is neither accepted nor errored.
- REQ-029 SHALL make the accept-to-RUN latency exactly GUARD_CYC+SETTLE_CYC+2 cycles.

Reset
- REQ-030 SHALL on rst go to IDLE next edge from any state, abandoning any in-flight sequence.
- REQ-031 SHALL reset sel=0, pad_oe=0, pad_ie=0, pad_a=0, pad_od=0, pad_os=0, pad_pu=0, pad_pd=1, pad_dr=0, pad_sr=0, cfg_err=0 and busy=0, with counters at 0.

Structure
- REQ-032 SHALL place the state encoding enum and default GUARD_CYC/SETTLE_CYC constants in a shared pinmux package.
- REQ-033 SHALL put the owner-select mux plus the RUN output register in one sub-module, pad_owner_mux; the FSM stays in pad_func_seq.

Verification
- REQ-034 SHALL check reset: assert rst mid-SETTLE -> next cycle IDLE, pad_pd=1, pad_oe=0, busy=0.
- REQ-035 SHALL check a switch: accept func=2, pu=1 with defaults -> pad_oe=0 for cycles 1..7, pad_pu=1 from cycle 3, pad_ie=1 from cycle 4, RUN at cycle 8, pad_oe follows fn_oe[2] from cycle 9.
- REQ-036 SHALL check an illegal pull: pu=pd=1 in RUN with func=1 -> cfg_err pulses once, pad outputs and state unchanged.
- REQ-037 SHALL check busy behaviour: cfg_valid held through DRAIN/SETTLE -> cfg_ready=0, no second accept until RUN, then accepted on the first RUN cycle.
- REQ-038 SHALL check input isolation: in RUN with func=3, toggle pad_y -> only fn_y[3] toggles; during DRAIN fn_y is all 0.
- REQ-039 SHALL check a same-function request: func=0 requested while func=0 is in RUN -> full 8-cycle sequence with pad_oe=0 throughout.

Source files
------------

// File: rtl/pad_func_seq_pkg.sv
// Shared pinmux definitions: sequencer state encoding, default timing and pad-config types.
package pad_func_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRAIN  = 3'd1,
      ST_SWITCH = 3'd2,
      ST_SETTLE = 3'd3,
      ST_RUN    = 3'd4
   } state_t;

   localparam int GUARD_CYC_DEF  = 2;
   localparam int SETTLE_CYC_DEF = 4;
   localparam int CNT_W          = 4;

   typedef struct packed {
      logic pu;
      logic pd;
      logic dr;
      logic sr;
   } pad_cfg_t;

   typedef struct packed {
      logic a;
      logic oe;
      logic od;
      logic os;
   } pad_drv_t;

   // Pad parks pulled down with weak/slow drive until software configures it.
   localparam pad_cfg_t PAD_CFG_RST = '{pu: 1'b0, pd: 1'b1, dr: 1'b0, sr: 1'b0};

   function automatic logic pull_conflict(input pad_cfg_t c);
      return c.pu & c.pd;
   endfunction

endpackage

// File: rtl/pad_owner_mux.sv
// Selects the active owner's drive controls through one register stage and
// routes the pad input back to that owner only.
module pad_owner_mux
   import pad_func_seq_pkg::*;
#(
   parameter int NFUNC = 4
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_run,
   input  logic [$clog2(NFUNC)-1:0] i_sel,
   input  logic [NFUNC-1:0]         i_fn_a,
   input  logic [NFUNC-1:0]         i_fn_oe,
   input  logic [NFUNC-1:0]         i_fn_od,
   input  logic [NFUNC-1:0]         i_fn_os,
   input  logic                     i_pad_y,
   input  logic                     i_pad_ie,
   output logic                     o_pad_a,
   output logic                     o_pad_oe,
   output logic                     o_pad_od,
   output logic                     o_pad_os,
   output logic [NFUNC-1:0]         o_fn_y
);

   pad_drv_t w_drv;
   pad_drv_t r_drv;

   assign w_drv = '{a: i_fn_a[i_sel], oe: i_fn_oe[i_sel],
                    od: i_fn_od[i_sel], os: i_fn_os[i_sel]};

   always_ff @(posedge i_clk) begin
      if (i_rst)      r_drv <= '0;
      else if (i_run) r_drv <= w_drv;
      else            r_drv <= '0;
   end

   // Gate with i_run so the first non-RUN cycle never sees a stale owner drive.
   assign o_pad_a  = r_drv.a  & i_run;
   assign o_pad_oe = r_drv.oe & i_run;
   assign o_pad_od = r_drv.od & i_run;
   assign o_pad_os = r_drv.os & i_run;

   always_comb begin
      o_fn_y        = '0;
      o_fn_y[i_sel] = i_pad_y & i_pad_ie;
   end

endmodule

// File: rtl/pad_func_seq.sv
// Pad function switch sequencer: drains the old owner, swaps function and pulls,
// lets the pad settle, then hands the pad to the new owner.
module pad_func_seq
   import pad_func_seq_pkg::*;
#(
   parameter int NFUNC      = 4,
   parameter int GUARD_CYC  = GUARD_CYC_DEF,
   parameter int SETTLE_CYC = SETTLE_CYC_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [$clog2(NFUNC)-1:0] cfg_func,
   input  logic                     cfg_pu,
   input  logic                     cfg_pd,
   input  logic                     cfg_dr,
   input  logic                     cfg_sr,
   output logic                     cfg_err,
   input  logic [NFUNC-1:0]         fn_a,
   input  logic [NFUNC-1:0]         fn_oe,
   input  logic [NFUNC-1:0]         fn_od,
   input  logic [NFUNC-1:0]         fn_os,
   output logic [NFUNC-1:0]         fn_y,
   output logic                     pad_a,
   output logic                     pad_oe,
   output logic                     pad_ie,
   output logic                     pad_od,
   output logic                     pad_os,
   output logic                     pad_pu,
   output logic                     pad_pd,
   output logic                     pad_dr,
   output logic                     pad_sr,
   input  logic                     pad_y,
   output logic                     busy
);

   localparam int               FW          = $clog2(NFUNC);
   localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYC - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
   localparam logic [FW-1:0]    FUNC_MAX    = FW'(NFUNC - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [FW-1:0]    r_sel;
   logic [FW-1:0]    r_lat_func;
   pad_cfg_t         r_pad_cfg;
   pad_cfg_t         r_lat_cfg;
   pad_cfg_t         w_req_cfg;
   logic             r_err;
   logic             w_ready;
   logic             w_run;
   logic             w_ie;
   logic             w_hs;
   logic             w_func_oob;
   logic             w_bad;
   logic             w_acc;
   logic             w_load;

   assign w_req_cfg = '{pu: cfg_pu, pd: cfg_pd, dr: cfg_dr, sr: cfg_sr};

   if ((1 << FW) == NFUNC) begin : g_func_full
      assign w_func_oob = 1'b0;
   end else begin : g_func_part
      assign w_func_oob = (cfg_func > FUNC_MAX);
   end

   assign w_hs   = cfg_valid & w_ready;
   assign w_bad  = pull_conflict(w_req_cfg) | w_func_oob;
   assign w_acc  = w_hs & ~w_bad;
   assign w_load = (r_state == ST_DRAIN) && (r_cnt == GUARD_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE,
         ST_RUN:    if (w_acc) w_state_nxt = ST_DRAIN;
         ST_DRAIN:  if (r_cnt == GUARD_LAST) w_state_nxt = ST_SWITCH;
         ST_SWITCH: w_state_nxt = ST_SETTLE;
         ST_SETTLE: if (r_cnt == SETTLE_LAST) w_state_nxt = ST_RUN;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      w_ready = 1'b0;
      w_run   = 1'b0;
      w_ie    = 1'b0;
      case (r_state)
         ST_IDLE:   w_ready = 1'b1;
         ST_SETTLE: w_ie    = 1'b1;
         ST_RUN: begin
            w_ready = 1'b1;
            w_run   = 1'b1;
            w_ie    = 1'b1;
         end
         default: ;
      endcase
   end

   // One shared counter: DRAIN and SETTLE never overlap, and it idles at 0.
   always_ff @(posedge clk) begin
      if (rst)
         r_cnt <= '0;
      else if ((r_state == ST_DRAIN  && r_cnt != GUARD_LAST) ||
               (r_state == ST_SETTLE && r_cnt != SETTLE_LAST))
         r_cnt <= r_cnt + CNT_W'(1);
      else
         r_cnt <= '0;
   end

   // The new function/pulls land on the DRAIN->SWITCH edge so they are live during SWITCH.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lat_func <= '0;
         r_lat_cfg  <= PAD_CFG_RST;
         r_sel      <= '0;
         r_pad_cfg  <= PAD_CFG_RST;
         r_err      <= 1'b0;
      end else begin
         r_err <= w_hs & w_bad;
         if (w_acc) begin
            r_lat_func <= cfg_func;
            r_lat_cfg  <= w_req_cfg;
         end
         if (w_load) begin
            r_sel     <= r_lat_func;
            r_pad_cfg <= r_lat_cfg;
         end
      end
   end

   pad_owner_mux #(.NFUNC(NFUNC)) u_owner_mux (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_run    (w_run),
      .i_sel    (r_sel),
      .i_fn_a   (fn_a),
      .i_fn_oe  (fn_oe),
      .i_fn_od  (fn_od),
      .i_fn_os  (fn_os),
      .i_pad_y  (pad_y),
      .i_pad_ie (w_ie),
      .o_pad_a  (pad_a),
      .o_pad_oe (pad_oe),
      .o_pad_od (pad_od),
      .o_pad_os (pad_os),
      .o_fn_y   (fn_y)
   );

   assign cfg_ready = w_ready;
   assign busy      = ~w_ready;
   assign cfg_err   = r_err;
   assign pad_ie    = w_ie;
   assign pad_pu    = r_pad_cfg.pu;
   assign pad_pd    = r_pad_cfg.pd;
   assign pad_dr    = r_pad_cfg.dr;
   assign pad_sr    = r_pad_cfg.sr;

endmodule

// File: tb/tb_pad_func_seq.sv
// Bench for pad_func_seq: timeline model of the switch sequence plus directed scenarios.
module tb_pad_func_seq;

   localparam int NF  = 4;
   localparam int G   = 2;
   localparam int S   = 4;
   localparam int LAT = G + S + 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          cfg_valid, cfg_ready, cfg_err;
   logic [1:0]    cfg_func;
   logic          cfg_pu, cfg_pd, cfg_dr, cfg_sr;
   logic [NF-1:0] fn_a, fn_oe, fn_od, fn_os, fn_y;
   logic          pad_a, pad_oe, pad_ie, pad_od, pad_os;
   logic          pad_pu, pad_pd, pad_dr, pad_sr, pad_y, busy;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   pad_func_seq #(.NFUNC(NF), .GUARD_CYC(G), .SETTLE_CYC(S)) dut (
      .clk(clk), .rst(rst),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_func(cfg_func),
      .cfg_pu(cfg_pu), .cfg_pd(cfg_pd), .cfg_dr(cfg_dr), .cfg_sr(cfg_sr),
      .cfg_err(cfg_err),
      .fn_a(fn_a), .fn_oe(fn_oe), .fn_od(fn_od), .fn_os(fn_os), .fn_y(fn_y),
      .pad_a(pad_a), .pad_oe(pad_oe), .pad_ie(pad_ie), .pad_od(pad_od),
      .pad_os(pad_os), .pad_pu(pad_pu), .pad_pd(pad_pd), .pad_dr(pad_dr),
      .pad_sr(pad_sr), .pad_y(pad_y), .busy(busy)
   );

   // Model: m_k counts cycles since the accepting edge (-1 when no sequence is in flight).
   bit m_vld = 1'b0;
   int m_k   = -1;
   bit m_run;
   int m_sel, n_sel;
   bit m_pu, m_pd, m_dr, m_sr, n_pu, n_pd, n_dr, n_sr;
   bit m_err, m_a, m_oe, m_od, m_os;

   always @(posedge clk) begin
      bit rdy, bad, inrun;
      if (rst) begin
         m_vld = 1'b1; m_k = -1; m_run = 1'b0; m_sel = 0; n_sel = 0;
         m_pu = 0; m_pd = 1; m_dr = 0; m_sr = 0;
         n_pu = 0; n_pd = 1; n_dr = 0; n_sr = 0;
         m_err = 0; m_a = 0; m_oe = 0; m_od = 0; m_os = 0;
      end else if (m_vld) begin
         rdy   = (m_k < 0);
         inrun = rdy && m_run;
         m_a   = inrun ? fn_a[m_sel]  : 1'b0;
         m_oe  = inrun ? fn_oe[m_sel] : 1'b0;
         m_od  = inrun ? fn_od[m_sel] : 1'b0;
         m_os  = inrun ? fn_os[m_sel] : 1'b0;
         bad   = (cfg_pu && cfg_pd) || (int'(cfg_func) >= NF);
         m_err = rdy && cfg_valid && bad;
         if (m_k >= 0) begin
            m_k++;
            if (m_k == G + 1) begin
               m_sel = n_sel; m_pu = n_pu; m_pd = n_pd; m_dr = n_dr; m_sr = n_sr;
            end
            if (m_k == LAT) begin
               m_k = -1; m_run = 1'b1;
            end
         end else if (rdy && cfg_valid && !bad) begin
            m_k = 1;
            n_sel = int'(cfg_func); n_pu = cfg_pu; n_pd = cfg_pd; n_dr = cfg_dr; n_sr = cfg_sr;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      bit e_run, e_busy, e_ie;
      logic [NF-1:0] e_fny;
      if (!m_vld || rst) return;
      e_busy = (m_k >= 0);
      e_run  = !e_busy && m_run;
      e_ie   = e_run || (m_k >= G + 2);
      e_fny  = '0;
      if (e_ie && pad_y) e_fny[m_sel] = 1'b1;
      chk("m_ready", 32'(cfg_ready), 32'(!e_busy));
      chk("m_busy",  32'(busy),      32'(e_busy));
      chk("m_err",   32'(cfg_err),   32'(m_err));
      chk("m_ie",    32'(pad_ie),    32'(e_ie));
      chk("m_oe",    32'(pad_oe),    32'(e_run && m_oe));
      chk("m_a",     32'(pad_a),     32'(e_run && m_a));
      chk("m_od",    32'(pad_od),    32'(e_run && m_od));
      chk("m_os",    32'(pad_os),    32'(e_run && m_os));
      chk("m_pull",  32'({pad_pu, pad_pd, pad_dr, pad_sr}), 32'({m_pu, m_pd, m_dr, m_sr}));
      chk("m_fny",   32'(fn_y),      32'(e_fny));
   endtask

   task automatic cyc();
      @(negedge clk);
      cmp_model();
      @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [1:0] f, input logic pu, input logic pd, input logic dr);
      cfg_valid = 1'b1; cfg_func = f; cfg_pu = pu; cfg_pd = pd; cfg_dr = dr; cfg_sr = 1'b0;
      cyc();
      cfg_valid = 1'b0; cfg_pu = 1'b0; cfg_pd = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_valid = 0; cfg_func = 0; cfg_pu = 0; cfg_pd = 0; cfg_dr = 0; cfg_sr = 0;
      fn_a = 0; fn_oe = 0; fn_od = 0; fn_os = 0; pad_y = 0;
      repeat (3) cyc();
      chk("rst_pd", 32'(pad_pd), 1);
      chk("rst_oe", 32'(pad_oe), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ready", 32'(cfg_ready), 1);
      rst = 1'b0;
      cyc();

      // Switch to func 2 with pull-up: timeline pinned by hand.
      fn_oe = 4'b0100; fn_a = 4'b0100; fn_od = 4'b0100; fn_os = 4'b0010;
      req(2'd2, 1'b1, 1'b0, 1'b1);
      for (int k = 1; k <= 9; k++) begin
         if (k <= 7) chk("sw_oe_off", 32'(pad_oe), 0);
         chk("sw_pu", 32'(pad_pu), 32'(k >= 3));
         chk("sw_ie", 32'(pad_ie), 32'(k >= 4));
         chk("sw_busy", 32'(busy), 32'(k < 8));
         if (k < 9) cyc();
      end
      chk("sw_oe_run", 32'(pad_oe), 1);
      chk("sw_a_run", 32'(pad_a), 1);
      chk("sw_os_run", 32'(pad_os), 0);
      fn_oe = 4'b0000;
      cyc();
      chk("sw_oe_follow", 32'(pad_oe), 0);

      // Illegal pull in RUN with func 1.
      req(2'd1, 1'b0, 1'b0, 1'b0);
      repeat (LAT - 1) cyc();
      fn_oe = 4'b0010;
      cyc(); cyc();
      chk("ill_oe_pre", 32'(pad_oe), 1);
      cfg_valid = 1; cfg_func = 2'd1; cfg_pu = 1; cfg_pd = 1;
      cyc();
      cfg_valid = 0; cfg_pu = 0; cfg_pd = 0;
      chk("ill_err", 32'(cfg_err), 1);
      chk("ill_busy", 32'(busy), 0);
      chk("ill_pull", 32'({pad_pu, pad_pd}), 0);
      chk("ill_oe", 32'(pad_oe), 1);
      cyc();
      chk("ill_err_once", 32'(cfg_err), 0);

      // cfg_valid held through the sequence: second accept only on the first RUN cycle.
      cfg_valid = 1; cfg_func = 2'd3; cfg_pu = 0; cfg_pd = 1; cfg_dr = 0;
      cyc();
      for (int k = 1; k <= 7; k++) begin
         chk("hold_ready", 32'(cfg_ready), 0);
         cyc();
      end
      chk("hold_run_ready", 32'(cfg_ready), 1);
      cyc();
      cfg_valid = 0;
      chk("hold_reaccept", 32'(busy), 1);
      repeat (LAT - 1) cyc();

      // Input isolation with func 3.
      pad_y = 1; #1;
      chk("iso_y1", 32'(fn_y), 32'h8);
      pad_y = 0; #1;
      chk("iso_y0", 32'(fn_y), 0);
      pad_y = 1;
      req(2'd0, 1'b0, 1'b1, 1'b0);
      chk("iso_drain", 32'(fn_y), 0);
      cyc();
      chk("iso_drain2", 32'(fn_y), 0);
      repeat (LAT - 2) cyc();
      chk("iso_run0", 32'(fn_y), 32'h1);

      // Same-function request: func 0 again, no short-cut.
      fn_oe = 4'b0001;
      cyc(); cyc();
      chk("same_oe_pre", 32'(pad_oe), 1);
      req(2'd0, 1'b0, 1'b1, 1'b0);
      for (int k = 1; k <= 8; k++) begin
         chk("same_oe_off", 32'(pad_oe), 0);
         chk("same_busy", 32'(busy), 32'(k < 8));
         cyc();
      end
      chk("same_oe_back", 32'(pad_oe), 1);

      // Reset mid-SETTLE.
      req(2'd2, 1'b1, 1'b0, 1'b1);
      repeat (4) cyc();
      chk("rs_settle_ie", 32'(pad_ie), 1);
      rst = 1;
      cyc();
      chk("rs_busy", 32'(busy), 0);
      chk("rs_pd", 32'(pad_pd), 1);
      chk("rs_oe", 32'(pad_oe), 0);
      chk("rs_idle_ie", 32'(pad_ie), 0);
      rst = 0;
      cyc();
      req(2'd1, 1'b0, 1'b1, 1'b0);
      chk("idle_accept", 32'(busy), 1);
      repeat (LAT + 1) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
